// File: rtl/riscv_multi_clk_en_ctrl.sv
// Per-core clock-gate enable controller for a multi-core RISC-V cluster.
// Each core runs an independent IDLE/RUN/DONE sequencer with run budget, single-step and cycle accounting.
module riscv_multi_clk_en_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 64,
    parameter int RUN_W     = 32
) (
    input  logic                       clk_in,
    input  logic                       resetb,
    input  logic [NUM_CORES-1:0]       core_resetb,
    input  logic [NUM_CORES-1:0]       clk_en_in,
    input  logic [NUM_CORES-1:0]       riscv_ready,
    input  logic [RUN_W-1:0]           run_cycle,
    input  logic                       run_cycle_enable,
    input  logic                       step_mode,
    input  logic                       step_pulse,
    input  logic                       cnt_clear,
    output logic [NUM_CORES-1:0]       clk_out_riscv_en,
    output logic [NUM_CORES-1:0]       riscv_run_done,
    output logic                       riscv_run_done_all,
    output logic [NUM_CORES*CNT_W-1:0] core_cycle_count,
    output logic [NUM_CORES-1:0]       core_cnt_sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [NUM_CORES-1:0] en_q;
    logic [NUM_CORES-1:0] done_q;
    logic [NUM_CORES-1:0] sat_q;

    generate
        for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
            state_t           state;
            state_t           state_nxt;
            logic             en_nxt;
            logic             done_nxt;
            logic             latch;
            logic             latch_nxt;
            logic             count_grant;
            logic [RUN_W-1:0] run_cnt;
            logic [CNT_W-1:0] tot_cnt;

            // IDLE and RUN share the same exit rules; ready beats the budget compare.
            always_comb begin
                state_nxt = state;
                en_nxt    = 1'b0;
                done_nxt  = done_q[i];
                latch_nxt = latch;
                if (!clk_en_in[i]) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b0;
                    latch_nxt = 1'b0;
                end else begin
                    case (state)
                        IDLE, RUN: begin
                            if (riscv_ready[i] || latch) begin
                                state_nxt = DONE;
                                done_nxt  = 1'b1;
                                latch_nxt = 1'b1;
                            end else if (run_cycle_enable && (run_cnt == run_cycle)) begin
                                state_nxt = DONE;
                                done_nxt  = 1'b1;
                            end else begin
                                state_nxt = RUN;
                                done_nxt  = 1'b0;
                                en_nxt    = step_mode ? step_pulse : 1'b1;
                            end
                        end
                        default: begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    endcase
                end
            end

            assign count_grant = en_nxt && core_resetb[i];

            always_ff @(posedge clk_in) begin
                if (!resetb) begin
                    state     <= IDLE;
                    en_q[i]   <= 1'b0;
                    done_q[i] <= 1'b0;
                    latch     <= 1'b0;
                    run_cnt   <= '0;
                    tot_cnt   <= '0;
                    sat_q[i]  <= 1'b0;
                end else begin
                    state     <= state_nxt;
                    en_q[i]   <= en_nxt;
                    done_q[i] <= done_nxt;
                    latch     <= latch_nxt;
                    if (!clk_en_in[i]) begin
                        run_cnt <= '0;
                    end else if (count_grant) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                    // Clear wins over a same-edge grant; a grant at all-ones only flags saturation.
                    if (cnt_clear) begin
                        tot_cnt  <= '0;
                        sat_q[i] <= 1'b0;
                    end else if (count_grant) begin
                        if (&tot_cnt) begin
                            sat_q[i] <= 1'b1;
                        end else begin
                            tot_cnt <= tot_cnt + 1'b1;
                        end
                    end
                end
            end

            assign core_cycle_count[i*CNT_W +: CNT_W] = tot_cnt;
        end
    endgenerate

    assign clk_out_riscv_en   = en_q;
    assign riscv_run_done     = done_q;
    assign core_cnt_sat       = sat_q;
    assign riscv_run_done_all = &done_q;

endmodule

// File: doc/riscv_multi_clk_en_ctrl.md
RISCV_MULTI_CLK_EN_CTRL -- requirements
Module: riscv_multi_clk_en_ctrl

Interface
REQ-001 Parameter NUM_CORES, default 4, number of independently gated cores (1..16).
REQ-002 Parameter CNT_W, default 64, width of each per-core total cycle counter.
REQ-003 Parameter RUN_W, default 32, width of the run-budget compare and per-core run counter.
REQ-004 Port clk_in  input  1  single clock; all logic SHALL be rising-edge clk_in only.
REQ-005 Port resetb  input  1  reset, synchronous and active-low.
REQ-006 Port core_resetb  input  NUM_CORES  per-core core reset (active-low); gates counting only.
REQ-007 Port clk_en_in  input  NUM_CORES  per-core run request; level-sensitive.
REQ-008 Port riscv_ready  input  NUM_CORES  per-core program-finished indication.
REQ-009 Port run_cycle  input  RUN_W  run budget, shared by all cores.
REQ-010 Port run_cycle_enable  input  1  enables the run budget.
REQ-011 Port step_mode  input  1  1 = single-step mode.
REQ-012 Port step_pulse  input  1  one-cycle step request, used only when step_mode=1.
REQ-013 Port cnt_clear  input  1  synchronous clear of total counters and saturation flags.
REQ-014 Port clk_out_riscv_en  output  NUM_CORES  registered per-core clock-gate enable.
REQ-015 Port riscv_run_done  output  NUM_CORES  registered per-core done flag.
REQ-016 Port riscv_run_done_all  output  1  combinational AND of all riscv_run_done bits.
REQ-017 Port core_cycle_count  output  NUM_CORES*CNT_W  flat total counters; core i at bits [i*CNT_W +: CNT_W].
REQ-018 Port core_cnt_sat  output  NUM_CORES  per-core sticky counter-saturated flag.

Function
REQ-019 Each core SHALL have an independent FSM: IDLE, RUN, DONE; cores SHALL NOT interact except through shared inputs.
REQ-020 Any state with clk_en_in[i]=0: next state IDLE, run counter 0, en 0, done 0, ready-latch 0; total counter held.
REQ-021 IDLE or RUN with clk_en_in[i]=1: priority order: (a) riscv_ready[i]=1 or ready-latch set -> DONE; (b) run_cycle_enable=1 and run counter == run_cycle -> DONE; (c) otherwise RUN.
REQ-022 On entering DONE, en SHALL go 0 and done SHALL go 1 at the same edge; riscv_ready[i]=1 SHALL set the ready-latch.
REQ-023 DONE SHALL persist, with en 0 and counters held, until clk_en_in[i]=0; ready deassertion SHALL NOT leave DONE.
REQ-024 In RUN, step_mode=0: en registered 1 every cycle.
REQ-025 In RUN, step_mode=1: en registered equal to step_pulse at that edge (one en cycle per pulse); back-to-back pulses give consecutive en cycles.
REQ-026 A grant is an edge at which en is registered 1; on a grant with core_resetb[i]=1, run counter and total counter SHALL each increment by 1 at that same edge.
REQ-027 On a grant with core_resetb[i]=0, en SHALL still be 1 but neither counter SHALL change.
REQ-028 run_cycle=0 with run_cycle_enable=1: core SHALL go IDLE->DONE with zero grants.
REQ-029 Changing run_cycle mid-run: compare uses the current value; if run counter already exceeds it, core SHALL run until clk_en_in drops or ready (no wrap-stop).
REQ-030 Run counter SHALL wrap modulo 2^RUN_W when run_cycle_enable=0.
REQ-031 Total counter SHALL saturate at all-ones; a grant at all-ones SHALL set core_cnt_sat[i] and hold the count.
REQ-032 cnt_clear=1 SHALL zero all total counters and sat flags at that edge, overriding any simultaneous increment; FSM, en, done, run counters unaffected.
REQ-033 Latency: clk_en_in rise to first en=1 is exactly 1 cycle; ready rise to en=0/done=1 is exactly 1 cycle.

Reset
REQ-034 resetb=0 at a rising edge SHALL force every core to IDLE; clk_out_riscv_en=0, riscv_run_done=0, core_cycle_count=0, core_cnt_sat=0, run counters and ready-latches 0.
REQ-035 resetb SHALL dominate cnt_clear and all functional inputs; reset mid-run SHALL take effect at the next edge with no further grant.
REQ-036 Outputs SHALL be X-free from the first edge with resetb=0.

Verification
REQ-037 NUM_CORES=4; core0 clk_en_in=1, run_cycle_enable=1, run_cycle=10, core_resetb=1 -> exactly 10 en cycles, done[0]=1 on the 11th edge, count0=10.
REQ-038 Core1 free-running (budget off); riscv_ready[1] pulsed one cycle at cycle 20 -> en[1]=0, done[1]=1 next edge and held after ready drops; count1=20.
REQ-039 step_mode=1, core2 enabled, 3 isolated step_pulses -> exactly 3 single-cycle en[2] pulses, count2=3.
REQ-040 CNT_W=4, core3 run 20 cycles -> count3 stops at 15, core_cnt_sat[3]=1; cnt_clear -> count3=0, sat=0, core3 keeps running.
REQ-041 All four cores reach DONE -> riscv_run_done_all=1; drop clk_en_in[0] -> done_all=0 next edge; resetb=0 mid-run -> all outputs 0 next edge.
